// File: rtl/quad_store_ser.sv
// Store path from a 64-bit register to a byte-wide RAM: narrows the value to
// the requested size and emits it as big-endian byte writes, one per handshake.
package quad_store_ser_pkg;
   localparam int RAM_QUAD_SIZE = 64;
   typedef enum logic [1:0] {
      RAM_BYTE = 2'd0,
      RAM_WORD = 2'd1,
      RAM_LONG = 2'd2,
      RAM_QUAD = 2'd3
   } data_type_t;
endpackage

module quad_store_ser
   import quad_store_ser_pkg::*;
#(
   parameter int ADDR_W = 16
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     req_valid,
   output logic                     req_ready,
   input  logic [ADDR_W-1:0]        req_addr,
   input  data_type_t               req_type,
   input  logic [RAM_QUAD_SIZE-1:0] req_data,
   output logic                     mem_we,
   output logic [ADDR_W-1:0]        mem_addr,
   output logic [7:0]               mem_data,
   input  logic                     mem_ready,
   output logic                     done,
   output logic                     err
);

   localparam logic [1:0] IDLE  = 2'd0;
   localparam logic [1:0] WRITE = 2'd1;
   localparam logic [1:0] DONE  = 2'd2;

   logic [1:0]               state_reg;
   logic [ADDR_W-1:0]        addr_reg;
   logic [3:0]               n_reg;
   logic [3:0]               i_reg;
   logic [RAM_QUAD_SIZE-1:0] sr_reg;
   logic                     err_reg;

   logic [3:0]               n_next;
   logic [RAM_QUAD_SIZE-1:0] sr_next;
   logic                     misaligned;
   logic                     write_active;

   // Byte count, left-justified shift value and alignment check per store size
   always_comb begin
      n_next     = 4'd1;
      sr_next    = {req_data[7:0], 56'd0};
      misaligned = 1'b0;
      case (req_type)
         RAM_BYTE: begin
            n_next     = 4'd1;
            sr_next    = {req_data[7:0], 56'd0};
            misaligned = 1'b0;
         end
         RAM_WORD: begin
            n_next     = 4'd2;
            sr_next    = {req_data[15:0], 48'd0};
            misaligned = req_addr[0];
         end
         RAM_LONG: begin
            n_next     = 4'd4;
            sr_next    = {req_data[31:0], 32'd0};
            misaligned = |req_addr[1:0];
         end
         RAM_QUAD: begin
            n_next     = 4'd8;
            sr_next    = req_data;
            misaligned = |req_addr[2:0];
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg <= IDLE;
         addr_reg  <= '0;
         n_reg     <= 4'd0;
         i_reg     <= 4'd0;
         sr_reg    <= '0;
         err_reg   <= 1'b0;
      end else begin
         case (state_reg)
            IDLE: begin
               if (req_valid) begin
                  addr_reg  <= req_addr;
                  n_reg     <= n_next;
                  i_reg     <= 4'd0;
                  sr_reg    <= sr_next;
                  err_reg   <= misaligned;
                  state_reg <= misaligned ? DONE : WRITE;
               end
            end
            WRITE: begin
               if (mem_ready) begin
                  i_reg  <= i_reg + 4'd1;
                  sr_reg <= {sr_reg[RAM_QUAD_SIZE-9:0], 8'd0};
                  if (i_reg == n_reg - 4'd1)
                     state_reg <= DONE;
               end
            end
            DONE:    state_reg <= IDLE;
            default: state_reg <= IDLE;
         endcase
      end
   end

   // Reset masks the strobes in its own cycle so an abort never lands a byte
   assign write_active = (state_reg == WRITE) && !rst;

   assign req_ready = (state_reg == IDLE);
   assign mem_we    = write_active;
   assign mem_addr  = write_active ? addr_reg + ADDR_W'(i_reg) : '0;
   assign mem_data  = write_active ? sr_reg[RAM_QUAD_SIZE-1 -: 8] : 8'd0;
   assign done      = (state_reg == DONE) && !rst;
   assign err       = done && err_reg;

endmodule

// File: doc/quad_store_ser.md
QUAD_STORE_SER -- requirements
Module: quad_store_ser

Interface
REQ-001 SHALL have parameter ADDR_W, default 16, byte-address width of the RAM port.
REQ-002 SHALL have port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-003 SHALL have port rst, input, 1, synchronous active-high reset.
REQ-004 SHALL have port req_valid, input, 1, a store request is presented.
REQ-005 SHALL have port req_ready, output, 1, the block can accept a request.
REQ-006 SHALL have port req_addr, input, ADDR_W, byte address of the store.
REQ-007 SHALL have port req_type, input, data_type_t, store size: RAM_BYTE, RAM_WORD, RAM_LONG or RAM_QUAD, for 1, 2, 4 or 8 bytes.
REQ-008 SHALL have port req_data, input, RAM_QUAD_SIZE, the value right-aligned in the low bits; higher bits are ignored.
REQ-009 SHALL have port mem_we, output, 1, byte write strobe.
REQ-010 SHALL have port mem_addr, output, ADDR_W, byte write address.
REQ-011 SHALL have port mem_data, output, 8, byte write data.
REQ-012 SHALL have port mem_ready, input, 1, the RAM accepts the write in the current cycle when mem_we=1.
REQ-013 SHALL have port done, output, 1, one-cycle pulse marking request completion.
REQ-014 SHALL have port err, output, 1, valid with done; 1 means the request was misaligned and nothing was written.

Function
REQ-015 SHALL implement the store path back to byte-wide RAM: it narrows a quad register value to req_type and serializes it into big-endian byte writes.
REQ-016 SHALL use states IDLE, WRITE and DONE.
REQ-017 SHALL drive req_ready=1 only in IDLE; a request is accepted on a cycle with req_valid & req_ready.
REQ-018 SHALL, on acceptance, latch the address, set byte count n from req_type, and load shift register sr = req_data << (64-8n), so the most significant byte of the value sits in sr[63:56].
REQ-019 SHALL treat a request as misaligned when req_addr mod n != 0.
REQ-020 SHALL, for a misaligned request, go IDLE->DONE with err=1 and assert mem_we on no cycle.
REQ-021 SHALL, for an aligned request, go IDLE->WRITE with a byte index i=0.
REQ-022 SHALL, in WRITE, drive mem_we=1, mem_addr = latched addr + i, and mem_data = sr[63:56].
REQ-023 SHALL, on a WRITE cycle with mem_ready=1, increment i and shift sr left by 8.
REQ-024 SHALL, on a WRITE cycle with mem_ready=0, hold mem_addr, mem_data and mem_we stable for as many stall cycles as occur.
REQ-025 SHALL move WRITE->DONE on the cycle the byte with i=n-1 is accepted.
REQ-026 SHALL, in DONE, assert done=1 for exactly one cycle, with err=1 for a misaligned request and err=0 otherwise, then return to IDLE.
REQ-027 SHALL give a store with no stalls this timing: acceptance at cycle 0, writes in cycles 1..n, done in cycle n+1, req_ready=1 again in cycle n+2.
REQ-028 SHALL use an address increment of width ADDR_W that wraps modulo 2^ADDR_W; this cannot happen for aligned requests.
REQ-029 SHALL drive mem_addr=0 and mem_data=0 while mem_we=0.
REQ-030 SHALL accept no new request outside IDLE; req_valid there is ignored and not queued.

Reset
REQ-031 SHALL, when rst=1, enter IDLE at the next edge with req_ready=1 and mem_we=0, done=0, err=0, mem_addr=0, mem_data=0, i=0, sr=0.
REQ-032 SHALL, when rst rises mid-WRITE, stop all further writes from the following cycle, complete no partial byte sequence and raise no done.
REQ-033 SHALL have rst take priority over a same-cycle request or write handshake.

Verification
REQ-034 SHALL be verified with a QUAD store: addr=0x0010, data=0x0123456789ABCDEF, mem_ready=1 -> eight writes to 0x10..0x17 with bytes 01,23,45,67,89,AB,CD,EF, then done=1, err=0 in cycle 9.
REQ-035 SHALL be verified with a WORD store: addr=0x0006, data=0xFFFF_FFFF_FFFF_BEEF -> writes 0x06=BE, 0x07=EF only, with the upper bits ignored.
REQ-036 SHALL be verified with a misaligned LONG store at addr=0x0002 -> no mem_we at any time, done=1 with err=1 in cycle 1.
REQ-037 SHALL be verified with a BYTE store at addr=0x0003, data=0x5A, and mem_ready held 0 for 3 cycles -> mem_we/addr/data held stable at 0x0003/0x5A, write accepted on cycle 4, done on cycle 5.
REQ-038 SHALL be verified with rst asserted after the 2nd byte of a QUAD store -> exactly 2 writes observed, no done, req_ready=1 after reset.
REQ-039 SHALL be verified with back-to-back requests where req_valid is held high -> the second request is accepted only in IDLE, and no byte writes overlap.
